fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-domain controller for the async FIFO. It owns the binary and Gray write pointers and synchronizes the read-domain Gray pointer into the write clock.
- It generates full, almost-full, fill count and a sticky overflow flag.
- Its binary pointer and full flag drive the write port of the dual-clock FIFO memory directly (pointer and full inputs). Its Gray pointer is exported to the read-domain controller.

Parameters:
- DEPTH, 512, number of FIFO entries; power of two, >= 4.
- ALMOST_FULL_THRESH, DEPTH-4, fill level (entries) at or above which o_almost_full is asserted; range 1..DEPTH.
- Local: AW = $clog2(DEPTH). Pointers are AW+1 bits, with the MSB as the wrap bit.

Ports:
- i_wr_clk  in  1  write clock
- i_wr_rst  in  1  reset, asynchronous, active-high
- i_wr_en  in  1  write request from producer
- i_g_rd_ptr  in  AW+1  Gray read pointer from read domain, unsynchronized
- i_clr_overflow  in  1  clears o_overflow
- o_b_wr_ptr  out  AW+1  binary write pointer, registered; low AW bits are the memory write address
- o_g_wr_ptr  out  AW+1  Gray write pointer, registered; to read-domain synchronizer
- o_full  out  1  FIFO full, registered
- o_almost_full  out  1  fill >= ALMOST_FULL_THRESH, registered
- o_wr_count  out  AW+1  write-side fill level 0..DEPTH, registered, conservative
- o_overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (async assert, sync release): o_b_wr_ptr, o_g_wr_ptr, o_wr_count, both sync stages = 0. o_full = 0, o_almost_full = 0, o_overflow = 0.
- Synchronizer: two flops on i_wr_clk. rq1 <= i_g_rd_ptr, rq2 <= rq1. rq2 is the only use of the read pointer. No logic between the stages.
- Accept: wr_ok = i_wr_en && !o_full.
- Binary pointer: b_next = o_b_wr_ptr + wr_ok, modulo 2^(AW+1) (natural wrap). The memory writes at the current o_b_wr_ptr address on the same edge that the pointer advances.
- Gray pointer: g_next = b_next ^ (b_next >> 1). o_g_wr_ptr <= g_next. Exactly one bit changes per accepted write.
- Full: o_full <= (g_next == {~rq2[AW:AW-1], rq2[AW-2:0]}).
  - o_full asserts on the same edge as the DEPTH-th outstanding write.
  - o_full releases no earlier than 3 wr_clk edges after the read pointer moves (2 sync edges + 1 register edge).
- Count: rd_bin = Gray-to-binary(rq2), computed as an XOR prefix from the MSB. o_wr_count <= b_next - rd_bin, modulo 2^(AW+1).
  - The count never exceeds DEPTH.
  - It may overstate the true fill by up to the sync latency; it never understates it.
- Almost-full: o_almost_full <= ((b_next - rd_bin) >= ALMOST_FULL_THRESH).
- Overflow: set when i_wr_en && o_full. Cleared by i_clr_overflow. If set and clear occur in the same cycle, set wins. The pointer does not move on a rejected write.
- Wrap-around: after 2*DEPTH accepted writes the pointer returns to 0. Full/empty distinction comes only from the MSB/Gray compare; no special case is needed.
- Simultaneous write and read-pointer change: both are applied in the same next-state computation. The read change becomes visible only after synchronization.
- Reset mid-operation: all state clears immediately. The read domain must be reset at the same time; a single-sided reset is out of scope.
- No combinational path from any input to any output.

Decomposition:
- Shared package fifo_pkg:
  - Binary-to-Gray and Gray-to-binary functions, parameterized by width.
  - Pointer-width localparam function (AW+1).
  - The read-domain controller uses the same functions.
- Sub-module sync_2ff:
  - Parameterized-width two-flop synchronizer with async active-high reset.
  - Reused by the read-side controller for the write pointer.

Test Plan (DEPTH=8, ALMOST_FULL_THRESH=6, i_g_rd_ptr held 0 unless stated):
- Reset check: assert i_wr_rst mid-clock with i_wr_en=1 -> all outputs 0 immediately. After release, the first write gives o_b_wr_ptr=1, o_g_wr_ptr=4'b0001.
- Fill: 8 consecutive writes -> o_almost_full rises on the edge of the 6th write. o_full rises on the edge of the 8th write. Final state: o_b_wr_ptr=4'b1000, o_g_wr_ptr=4'b1100, o_wr_count=8.
- Overflow: from full, pulse i_wr_en 1 cycle -> pointer stays 8, o_overflow=1. Pulse i_clr_overflow alone -> 0. Assert i_wr_en and i_clr_overflow together while full -> o_overflow stays 1.
- Full release latency: from full, set i_g_rd_ptr=4'b0001 -> o_full stays 1 for 2 edges and goes 0 after the 3rd edge. o_wr_count=7 on that same edge.
- Wrap-around: read pointer tracks writes with lag <= 4 (Gray inputs) over 20 writes -> o_b_wr_ptr reads 4'b0100. The pointer passed through 4'b1111 -> 4'b0000. o_full never asserts. Gray output changes exactly 1 bit per write.
- Random stress: random i_wr_en and a legal monotonic Gray read pointer for 10k cycles. Scoreboard checks:
  - o_wr_count >= true fill and <= DEPTH.
  - No accepted write while o_full=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-domain FIFO controllers.
// Conversions work on a wide word; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

  localparam int unsigned MAX_PW = 32;

  typedef logic [MAX_PW-1:0] ptr_word_t;

  // Pointer width for a FIFO of the given depth: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer-side bundle of the FIFO write controller.
// The master modport is the producer, the slave modport is the controller.
interface fifo_wr_ctrl_if #(
  parameter int unsigned DEPTH = 512
);
  import fifo_pkg::*;

  localparam int unsigned PW = ptr_width(DEPTH);

  logic          i_wr_en;
  logic [PW-1:0] i_g_rd_ptr;
  logic          i_clr_overflow;
  logic [PW-1:0] o_b_wr_ptr;
  logic [PW-1:0] o_g_wr_ptr;
  logic          o_full;
  logic          o_almost_full;
  logic [PW-1:0] o_wr_count;
  logic          o_overflow;

  modport master (
    output i_wr_en, i_g_rd_ptr, i_clr_overflow,
    input  o_b_wr_ptr, o_g_wr_ptr, o_full, o_almost_full, o_wr_count, o_overflow
  );

  modport slave (
    input  i_wr_en, i_g_rd_ptr, i_clr_overflow,
    output o_b_wr_ptr, o_g_wr_ptr, o_full, o_almost_full, o_wr_count, o_overflow
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into i_clk.
// No logic between the stages, so only one bit can be caught mid-transition.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: binary/Gray write pointers,
// synchronized read pointer, full / almost-full / fill count / sticky overflow.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH              = 512,
  parameter int unsigned ALMOST_FULL_THRESH = DEPTH - 4
) (
  input  logic         i_wr_clk,
  input  logic         i_wr_rst,
  fifo_wr_ctrl_if.slave wr_if
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0] r_b_wr_ptr;
  logic [PW-1:0] r_g_wr_ptr;
  logic [PW-1:0] r_wr_count;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic [PW-1:0] w_rq2;
  logic          w_wr_ok;
  logic [PW-1:0] w_b_next;
  logic [PW-1:0] w_g_next;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_fill;
  logic [PW-1:0] w_full_pat;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rd_ptr_sync (
    .i_clk (i_wr_clk),
    .i_rst (i_wr_rst),
    .i_d   (wr_if.i_g_rd_ptr),
    .o_q   (w_rq2)
  );

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    w_wr_ok    = wr_if.i_wr_en && !r_full;
    w_b_next   = r_b_wr_ptr + PW'(w_wr_ok);
    w_g_next   = PW'(bin2gray(MAX_PW'(w_b_next)));
    w_rd_bin   = PW'(gray2bin(MAX_PW'(w_rq2)));
    w_fill     = w_b_next - w_rd_bin;
    // Full when the write pointer is one lap ahead: Gray form flips the top two bits.
    w_full_pat = {~w_rq2[PW-1:PW-2], w_rq2[PW-3:0]};
  end

  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
    if (i_wr_rst) begin
      r_b_wr_ptr    <= '0;
      r_g_wr_ptr    <= '0;
      r_wr_count    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_b_wr_ptr    <= w_b_next;
      r_g_wr_ptr    <= w_g_next;
      r_wr_count    <= w_fill;
      r_full        <= (w_g_next == w_full_pat);
      r_almost_full <= (w_fill >= PW'(ALMOST_FULL_THRESH));
      // Set has priority over clear so a rejected write is never lost.
      if (wr_if.i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (wr_if.i_clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign wr_if.o_b_wr_ptr    = r_b_wr_ptr;
  assign wr_if.o_g_wr_ptr    = r_g_wr_ptr;
  assign wr_if.o_wr_count    = r_wr_count;
  assign wr_if.o_full        = r_full;
  assign wr_if.o_almost_full = r_almost_full;
  assign wr_if.o_overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl at DEPTH=8, ALMOST_FULL_THRESH=6.
// Stimulus pushes expected results per edge; a negedge monitor pops and compares.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_wr_ctrl_if #(.DEPTH(DEPTH)) intf ();

  fifo_wr_ctrl #(
    .DEPTH              (DEPTH),
    .ALMOST_FULL_THRESH (6)
  ) dut (
    .i_wr_clk (clk),
    .i_wr_rst (rst),
    .wr_if    (intf)
  );

  // -1 in a numeric field means "not checked for this edge".
  typedef struct {
    string name;
    int    cyc;
    int    b, g, cnt, full, af, ovf;
    bit    g1;
    bit    stress;
    bit    wen;
    int    rd;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    if (exp >= 0) check(name, act, 32'(exp));
  endtask

  function automatic logic [3:0] gray4(input int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction

  task automatic drive(input bit wen, input bit clr, input logic [3:0] rd, input string name,
                       input int b, input int g, input int cnt, input int full,
                       input int af, input int ovf, input bit g1 = 1'b0);
    exp_t e;
    @(negedge clk);
    intf.i_wr_en        = wen;
    intf.i_clr_overflow = clr;
    intf.i_g_rd_ptr     = rd;
    e = '{name: name, cyc: cyc + 1, b: b, g: g, cnt: cnt, full: full, af: af, ovf: ovf,
          g1: g1, stress: 1'b0, wen: wen, rd: -1};
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".b"},    32'(intf.o_b_wr_ptr), 0);
    check({name, ".g"},    32'(intf.o_g_wr_ptr), 0);
    check({name, ".cnt"},  32'(intf.o_wr_count), 0);
    check({name, ".full"}, 32'(intf.o_full), 0);
    check({name, ".af"},   32'(intf.o_almost_full), 0);
    check({name, ".ovf"},  32'(intf.o_overflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    intf.i_wr_en = 1'b0;
    intf.i_clr_overflow = 1'b0;
    intf.i_g_rd_ptr = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every pending expectation against the DUT each negedge.
  logic [3:0] prev_b = '0, prev_g = '0;
  logic       prev_full = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check({e.name, ".edge"}, 32'(cyc), 32'(e.cyc));
        cmp({e.name, ".b"},    32'(intf.o_b_wr_ptr),    e.b);
        cmp({e.name, ".g"},    32'(intf.o_g_wr_ptr),    e.g);
        cmp({e.name, ".cnt"},  32'(intf.o_wr_count),    e.cnt);
        cmp({e.name, ".full"}, 32'(intf.o_full),        e.full);
        cmp({e.name, ".af"},   32'(intf.o_almost_full), e.af);
        cmp({e.name, ".ovf"},  32'(intf.o_overflow),    e.ovf);
        if (e.g1)
          check({e.name, ".gray_1bit"}, 32'($countones(intf.o_g_wr_ptr ^ prev_g)), 1);
        if (e.stress) begin
          check("stress.ptr_step", 32'(4'(intf.o_b_wr_ptr - prev_b)),
                (e.wen && !prev_full) ? 32'd1 : 32'd0);
          check("stress.cnt_le_depth", 32'(intf.o_wr_count <= 4'(DEPTH)), 1);
          check("stress.cnt_ge_fill",
                32'(intf.o_wr_count >= 4'(intf.o_b_wr_ptr - 4'(e.rd))), 1);
        end
      end
      prev_b    = intf.o_b_wr_ptr;
      prev_g    = intf.o_g_wr_ptr;
      prev_full = intf.o_full;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  localparam logic [3:0] GRAY_TAB [1:8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

  initial begin
    int rd_b;
    intf.i_wr_en = 1'b0;
    intf.i_clr_overflow = 1'b0;
    intf.i_g_rd_ptr = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset_init");
    rst = 1'b0;

    for (int k = 1; k <= 3; k++)
      drive(1, 0, 4'd0, "pre_reset_wr", k, GRAY_TAB[k], k, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a high clock phase with i_wr_en held.
    @(negedge clk);
    @(posedge clk);
    #2;
    intf.i_wr_en = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    intf.i_wr_en = 1'b0;

    // Fill: almost-full on 6th write, full on 8th.
    for (int k = 1; k <= 8; k++)
      drive(1, 0, 4'd0, "fill_wr", k, GRAY_TAB[k], k, (k == 8) ? 1 : 0, (k >= 6) ? 1 : 0, 0, 1);

    // Overflow: rejected write, clear, set-wins-over-clear.
    drive(1, 0, 4'd0, "ovf_set",      8, 12, 8, 1, 1, 1);
    drive(0, 1, 4'd0, "ovf_clr",      8, 12, 8, 1, 1, 0);
    drive(1, 1, 4'd0, "ovf_set_wins", 8, 12, 8, 1, 1, 1);
    drive(0, 1, 4'd0, "ovf_clr2",     8, 12, 8, 1, 1, 0);

    // Full release: read pointer moves to 1; full drops after the 3rd edge.
    drive(0, 0, 4'b0001, "release_e1", 8, 12, 8, 1, 1, 0);
    drive(0, 0, 4'b0001, "release_e2", 8, 12, 8, 1, 1, 0);
    drive(0, 0, 4'b0001, "release_e3", 8, 12, 7, 0, 1, 0);
    drive(1, 0, 4'b0001, "refill",     9, 13, 8, 1, 1, 0, 1);

    // Wrap-around: read pointer trails by 4 writes; 20 writes end at pointer 4.
    @(negedge clk);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      int r;
      r = (k > 4) ? k - 4 : 0;
      drive(1, 0, gray4(r & 15), (k == 20) ? "wrap_end" : "wrap_wr",
            k & 15, 32'(gray4(k & 15)), (k < 6) ? k : 6, 0, (k >= 6) ? 1 : 0, 0, 1);
    end

    // Random stress with a monotonic read pointer that never passes the write pointer.
    @(negedge clk);
    do_reset();
    rd_b = 0;
    for (int i = 0; i < 10000; i++) begin
      exp_t e;
      bit   wen;
      @(negedge clk);
      if (4'(intf.o_b_wr_ptr - 4'(rd_b)) != 4'd0 && $urandom_range(0, 9) < 4)
        rd_b = (rd_b + 1) & 15;
      wen = ($urandom_range(0, 9) < 7);
      intf.i_wr_en        = wen;
      intf.i_clr_overflow = ($urandom_range(0, 15) == 0);
      intf.i_g_rd_ptr     = gray4(rd_b);
      e = '{name: "stress", cyc: cyc + 1, b: -1, g: -1, cnt: -1, full: -1, af: -1, ovf: -1,
            g1: 1'b0, stress: 1'b1, wen: wen, rd: rd_b};
      q.push_back(e);
    end

    @(negedge clk);
    intf.i_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
